// File: rtl/demo_pattern_gen.sv
// -----------------------------------------------------------------------------
// demo_pattern_gen
// Bring-up stand-in for the accelerometer front end on the terminal print
// path. Every TICK_CYCLES clocks it produces a new frame of ASCII digits
// (X/Y/Z: 4 digits, T: 6 digits) plus sign flags, pulses
// data_ready_for_printing for one cycle, and respects hold and printer
// back-pressure. Three patterns: TOGGLE (all 1s / all 0s), COUNT (BCD
// up-counter with Y = COUNT_MAX - v) and SWEEP (signed triangle wave).
//
// Ports:
//   clk                      system clock
//   reset                    synchronous, active-low reset
//   mode[1:0]                0 TOGGLE, 1 COUNT, 2 SWEEP, 3 TOGGLE
//   hold                     1 = no steps, pending tick discarded
//   printer_busy             1 = printer cannot take a frame yet
//   data_ready_for_printing  one-cycle strobe with each new frame
//   ascii_X1..X4, Y1..Y4, Z1..Z4, T1..T6   digits, index 1 = most significant
//   is_negative_X/Y/Z/T      sign flags (T is always 0)
// -----------------------------------------------------------------------------
module demo_pattern_gen #(
    parameter int TICK_CYCLES = 100000000,
    parameter int COUNT_MAX   = 9999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       hold,
    input  logic       printer_busy,
    output logic       data_ready_for_printing,
    output logic [7:0] ascii_X1,
    output logic [7:0] ascii_X2,
    output logic [7:0] ascii_X3,
    output logic [7:0] ascii_X4,
    output logic [7:0] ascii_Y1,
    output logic [7:0] ascii_Y2,
    output logic [7:0] ascii_Y3,
    output logic [7:0] ascii_Y4,
    output logic [7:0] ascii_Z1,
    output logic [7:0] ascii_Z2,
    output logic [7:0] ascii_Z3,
    output logic [7:0] ascii_Z4,
    output logic [7:0] ascii_T1,
    output logic [7:0] ascii_T2,
    output logic [7:0] ascii_T3,
    output logic [7:0] ascii_T4,
    output logic [7:0] ascii_T5,
    output logic [7:0] ascii_T6,
    output logic       is_negative_X,
    output logic       is_negative_Y,
    output logic       is_negative_Z,
    output logic       is_negative_T
);

    localparam int         CW         = $clog2(TICK_CYCLES);
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_SWEEP = 2'd2;

    // Elaboration-time conversion of the magnitude limit to 4 BCD digits.
    function automatic logic [15:0] to_bcd4(input int n);
        logic [15:0] r;
        int          m;
        r = 16'h0000;
        m = n;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    localparam logic [15:0] CMAX_BCD = to_bcd4(COUNT_MAX);

    // 4-digit BCD increment with digit carry.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c && (r[i*4 +: 4] == 4'd9)) begin
                r[i*4 +: 4] = 4'd0;
            end else if (c) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                c           = 1'b0;
            end else begin
                c = 1'b0;
            end
        end
        return r;
    endfunction

    // 4-digit BCD decrement with digit borrow (caller never passes 0000).
    function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b && (r[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = 4'd9;
            end else if (b) begin
                r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                b           = 1'b0;
            end else begin
                b = 1'b0;
            end
        end
        return r;
    endfunction

    // 6-digit BCD increment; 999999 naturally rolls to 000000.
    function automatic logic [23:0] bcd6_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c && (r[i*4 +: 4] == 4'd9)) begin
                r[i*4 +: 4] = 4'd0;
            end else if (c) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                c           = 1'b0;
            end else begin
                c = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] asc(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    // State
    logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               pending_q, pending_d;
    logic [1:0]         mode_q, mode_d;
    logic               phase_q, phase_d;
    logic [15:0]        v_q, v_d;
    logic [15:0]        y_q, y_d;
    logic [15:0]        mag_q, mag_d;
    logic               neg_q, neg_d;
    logic               dir_q, dir_d;         // 0 = up, 1 = down
    logic [23:0]        t_q, t_d;
    logic [0:17][7:0]   dig_q, dig_d;         // X1..X4, Y1..Y4, Z1..Z4, T1..T6
    logic [3:0]         sign_q, sign_d;       // {X, Y, Z, T}
    logic               strobe_q, strobe_d;

    // Combinational helpers
    logic               tick_s;
    logic               mode_chg_s;
    logic               fire_s;
    logic [23:0]        t_n_s;
    logic [15:0]        v_n_s, y_n_s;
    logic [15:0]        smag_n_s;
    logic               sneg_n_s, sdir_n_s;

    // Tick timing, pending tracking and the step decision.
    always_comb begin
        tick_s     = (tick_cnt_q == CW'(TICK_CYCLES - 1));
        tick_cnt_d = tick_s ? {CW{1'b0}} : tick_cnt_q + CW'(1);
        mode_d     = mode;
        mode_chg_s = (mode != mode_q);
        // A tick in the current cycle can fire the step directly; a mode
        // change suppresses the step but leaves pending alone.
        fire_s     = (pending_q | tick_s) & ~hold & ~printer_busy & ~mode_chg_s;
        if (hold) begin
            pending_d = 1'b0;
        end else if (fire_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q | tick_s;
        end
    end

    // Candidate next values for the COUNT and SWEEP patterns.
    always_comb begin
        t_n_s = bcd6_inc(t_q);
        if (v_q == CMAX_BCD) begin
            v_n_s = 16'h0000;
            y_n_s = CMAX_BCD;
        end else begin
            v_n_s = bcd4_inc(v_q);
            y_n_s = bcd4_dec(y_q);
        end

        smag_n_s = mag_q;
        sneg_n_s = neg_q;
        sdir_n_s = dir_q;
        if (!dir_q) begin
            if (!neg_q && (mag_q == CMAX_BCD)) begin
                sdir_n_s = 1'b1;
                smag_n_s = bcd4_dec(mag_q);
            end else if (neg_q) begin
                smag_n_s = bcd4_dec(mag_q);
            end else begin
                smag_n_s = bcd4_inc(mag_q);
            end
        end else begin
            if (neg_q && (mag_q == CMAX_BCD)) begin
                sdir_n_s = 1'b0;
                smag_n_s = bcd4_dec(mag_q);
            end else if (!neg_q && (mag_q != 16'h0000)) begin
                smag_n_s = bcd4_dec(mag_q);
            end else begin
                smag_n_s = bcd4_inc(mag_q);
                sneg_n_s = 1'b1;
            end
        end
        // Sign-magnitude zero is always +0.
        sneg_n_s = sneg_n_s & (smag_n_s != 16'h0000);
    end

    // Pattern state and output frame update.
    always_comb begin
        phase_d  = phase_q;
        v_d      = v_q;
        y_d      = y_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        dir_d    = dir_q;
        t_d      = t_q;
        dig_d    = dig_q;
        sign_d   = sign_q;
        strobe_d = 1'b0;

        if (mode_chg_s) begin
            phase_d = 1'b0;
            v_d     = 16'h0000;
            y_d     = CMAX_BCD;
            mag_d   = 16'h0000;
            neg_d   = 1'b0;
            dir_d   = 1'b0;
            t_d     = 24'h000000;
            dig_d   = {18{8'h30}};
            sign_d  = 4'b0000;
        end else if (fire_s) begin
            strobe_d = 1'b1;
            t_d      = t_n_s;
            for (int i = 0; i < 6; i++) begin
                dig_d[12 + i] = asc(t_n_s[(5 - i)*4 +: 4]);
            end
            case (mode_q)
                MODE_COUNT: begin
                    v_d = v_n_s;
                    y_d = y_n_s;
                    for (int i = 0; i < 4; i++) begin
                        dig_d[i]     = asc(v_n_s[(3 - i)*4 +: 4]);
                        dig_d[4 + i] = asc(y_n_s[(3 - i)*4 +: 4]);
                        dig_d[8 + i] = asc(v_n_s[(3 - i)*4 +: 4]);
                    end
                    sign_d = 4'b0000;
                end
                MODE_SWEEP: begin
                    mag_d = smag_n_s;
                    neg_d = sneg_n_s;
                    dir_d = sdir_n_s;
                    for (int i = 0; i < 4; i++) begin
                        dig_d[i]     = asc(smag_n_s[(3 - i)*4 +: 4]);
                        dig_d[4 + i] = asc(smag_n_s[(3 - i)*4 +: 4]);
                        dig_d[8 + i] = 8'h30;
                    end
                    // Y shows the mirrored sign; zero carries no sign at all.
                    sign_d = {sneg_n_s, ~sneg_n_s & (smag_n_s != 16'h0000), 1'b0, 1'b0};
                end
                default: begin
                    phase_d = ~phase_q;
                    dig_d   = {18{asc({3'b000, ~phase_q})}};
                    sign_d  = 4'b0000;
                end
            endcase
        end else begin
            strobe_d = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= {CW{1'b0}};
            pending_q  <= 1'b0;
            mode_q     <= 2'd0;
            phase_q    <= 1'b0;
            v_q        <= 16'h0000;
            y_q        <= CMAX_BCD;
            mag_q      <= 16'h0000;
            neg_q      <= 1'b0;
            dir_q      <= 1'b0;
            t_q        <= 24'h000000;
            dig_q      <= {18{8'h30}};
            sign_q     <= 4'b0000;
            strobe_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            phase_q    <= phase_d;
            v_q        <= v_d;
            y_q        <= y_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            dir_q      <= dir_d;
            t_q        <= t_d;
            dig_q      <= dig_d;
            sign_q     <= sign_d;
            strobe_q   <= strobe_d;
        end
    end

    assign data_ready_for_printing = strobe_q;
    assign ascii_X1 = dig_q[0];
    assign ascii_X2 = dig_q[1];
    assign ascii_X3 = dig_q[2];
    assign ascii_X4 = dig_q[3];
    assign ascii_Y1 = dig_q[4];
    assign ascii_Y2 = dig_q[5];
    assign ascii_Y3 = dig_q[6];
    assign ascii_Y4 = dig_q[7];
    assign ascii_Z1 = dig_q[8];
    assign ascii_Z2 = dig_q[9];
    assign ascii_Z3 = dig_q[10];
    assign ascii_Z4 = dig_q[11];
    assign ascii_T1 = dig_q[12];
    assign ascii_T2 = dig_q[13];
    assign ascii_T3 = dig_q[14];
    assign ascii_T4 = dig_q[15];
    assign ascii_T5 = dig_q[16];
    assign ascii_T6 = dig_q[17];
    assign is_negative_X = sign_q[3];
    assign is_negative_Y = sign_q[2];
    assign is_negative_Z = sign_q[1];
    assign is_negative_T = sign_q[0];

endmodule

// File: tb/tb_demo_pattern_gen.sv
module tb_demo_pattern_gen;

    localparam int TICK = 10;
    localparam int CMAX = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       hold = 1'b0;
    logic       printer_busy = 1'b0;
    logic       strobe;
    logic [7:0] x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4;
    logic [7:0] t1, t2, t3, t4, t5, t6;
    logic       nx, ny, nz, nt;

    demo_pattern_gen #(.TICK_CYCLES(TICK), .COUNT_MAX(CMAX)) dut (
        .clk(clk), .reset(reset), .mode(mode), .hold(hold), .printer_busy(printer_busy),
        .data_ready_for_printing(strobe),
        .ascii_X1(x1), .ascii_X2(x2), .ascii_X3(x3), .ascii_X4(x4),
        .ascii_Y1(y1), .ascii_Y2(y2), .ascii_Y3(y3), .ascii_Y4(y4),
        .ascii_Z1(z1), .ascii_Z2(z2), .ascii_Z3(z3), .ascii_Z4(z4),
        .ascii_T1(t1), .ascii_T2(t2), .ascii_T3(t3), .ascii_T4(t4), .ascii_T5(t5), .ascii_T6(t6),
        .is_negative_X(nx), .is_negative_Y(ny), .is_negative_Z(nz), .is_negative_T(nt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:17][7:0] dig;
        logic [3:0]       neg;
    } frame_t;

    typedef struct {
        int m; int k; int x; bit vx; int y; bit vy; int z; int t;
    } vec_t;

    frame_t dut_f;
    assign dut_f = {x1, x2, x3, x4, y1, y2, y3, y4, z1, z2, z3, z4,
                    t1, t2, t3, t4, t5, t6, nx, ny, nz, nt};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;
    bit prev_strobe = 1'b0;
    int cur_mode = 0;
    int k = 0;
    frame_t exp_q[$];
    int     tag_q[$];
    frame_t dut_log[int];
    vec_t   vecs[19];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_frame(input string name, input frame_t act, input frame_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(int x, int y, int z, int t, bit sx, bit sy);
        frame_t f;
        int n;
        f = '0;
        n = x; for (int i = 3; i >= 0; i--) begin f.dig[i] = 8'h30 + 8'(n % 10); n = n / 10; end
        n = y; for (int i = 7; i >= 4; i--) begin f.dig[i] = 8'h30 + 8'(n % 10); n = n / 10; end
        n = z; for (int i = 11; i >= 8; i--) begin f.dig[i] = 8'h30 + 8'(n % 10); n = n / 10; end
        n = t; for (int i = 17; i >= 12; i--) begin f.dig[i] = 8'h30 + 8'(n % 10); n = n / 10; end
        f.neg = {sx, sy, 2'b00};
        return f;
    endfunction

    // Expected frame after k steps since the last clear, from the closed forms.
    function automatic frame_t exp_frame(int m, int kk);
        int v, p, s, a;
        if (m == 1) begin
            v = kk % (CMAX + 1);
            return mk(v, CMAX - v, v, kk % 1000000, 1'b0, 1'b0);
        end else if (m == 2) begin
            p = kk % (4 * CMAX);
            if (p <= CMAX) s = p;
            else if (p <= 3 * CMAX) s = 2 * CMAX - p;
            else s = p - 4 * CMAX;
            a = (s < 0) ? -s : s;
            return mk(a, a, 0, kk % 1000000, s < 0, s > 0);
        end else begin
            if (kk % 2 == 1) return mk(1111, 1111, 1111, 111111, 1'b0, 1'b0);
            else return mk(0, 0, 0, 0, 1'b0, 1'b0);
        end
    endfunction

    // Scoreboard side: every strobe pops and compares one expected frame.
    always @(negedge clk) begin
        frame_t e;
        int tg;
        if (strobe) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            check_int("strobe_width", int'(prev_strobe), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe at cycle %0d actual=1 required=0", cyc);
            end else begin
                e  = exp_q.pop_front();
                tg = tag_q.pop_front();
                dut_log[tg] = dut_f;
                check_frame("frame", dut_f, e);
            end
        end
        prev_strobe = strobe;
    end

    task automatic wait_strobe();
        int c0;
        int b;
        c0 = strobe_cnt;
        b = 0;
        while (strobe_cnt == c0 && b < 4 * TICK) begin
            @(negedge clk); #1;
            b++;
        end
        if (strobe_cnt == c0) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout actual=none required=strobe (cycle %0d)", cyc);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    task automatic expect_step();
        k++;
        exp_q.push_back(exp_frame(cur_mode, k));
        tag_q.push_back(cur_mode * 1000 + k);
        wait_strobe();
    endtask

    task automatic switch_mode(input int m);
        mode = 2'(m);
        @(posedge clk); #1;
        check_frame("mode_change_clear", dut_f, mk(0, 0, 0, 0, 1'b0, 1'b0));
        check_int("mode_change_no_strobe", int'(strobe), 0);
        cur_mode = m;
        k = 0;
    endtask

    initial begin
        int rel_cyc, prev_cyc, low_cyc, tg;
        frame_t frozen;

        vecs[0]  = '{0, 1, 1111, 1'b0, 1111, 1'b0, 1111, 111111};
        vecs[1]  = '{0, 2, 0, 1'b0, 0, 1'b0, 0, 0};
        vecs[2]  = '{0, 3, 1111, 1'b0, 1111, 1'b0, 1111, 111111};
        vecs[3]  = '{1, 1, 1, 1'b0, 11, 1'b0, 1, 1};
        vecs[4]  = '{1, 12, 12, 1'b0, 0, 1'b0, 12, 12};
        vecs[5]  = '{1, 13, 0, 1'b0, 12, 1'b0, 0, 13};
        vecs[6]  = '{1, 100, 9, 1'b0, 3, 1'b0, 9, 100};
        vecs[7]  = '{1, 104, 0, 1'b0, 12, 1'b0, 0, 104};
        vecs[8]  = '{2, 1, 1, 1'b0, 1, 1'b1, 0, 1};
        vecs[9]  = '{2, 12, 12, 1'b0, 12, 1'b1, 0, 12};
        vecs[10] = '{2, 13, 11, 1'b0, 11, 1'b1, 0, 13};
        vecs[11] = '{2, 24, 0, 1'b0, 0, 1'b0, 0, 24};
        vecs[12] = '{2, 25, 1, 1'b1, 1, 1'b0, 0, 25};
        vecs[13] = '{2, 36, 12, 1'b1, 12, 1'b0, 0, 36};
        vecs[14] = '{2, 37, 11, 1'b1, 11, 1'b0, 0, 37};
        vecs[15] = '{2, 48, 0, 1'b0, 0, 1'b0, 0, 48};
        vecs[16] = '{2, 49, 1, 1'b0, 1, 1'b1, 0, 49};
        vecs[17] = '{3, 1, 1111, 1'b0, 1111, 1'b0, 1111, 111111};
        vecs[18] = '{1, 105, 1, 1'b0, 11, 1'b0, 1, 105};

        // Reset state and first-strobe timing
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_frame("reset_frame", dut_f, mk(0, 0, 0, 0, 1'b0, 1'b0));
        check_int("reset_strobe", int'(strobe), 0);
        reset = 1'b1;
        rel_cyc = cyc;
        repeat (3) @(posedge clk);
        #1;
        check_frame("idle_after_reset", dut_f, mk(0, 0, 0, 0, 1'b0, 1'b0));
        cur_mode = 0;
        k = 0;
        expect_step();
        check_int("first_strobe_delay", last_strobe_cyc - rel_cyc, TICK);

        // TOGGLE: period and stability between strobes
        for (int i = 0; i < 3; i++) begin
            prev_cyc = last_strobe_cyc;
            repeat (4) @(posedge clk);
            #1;
            check_frame("stable_between_steps", dut_f, exp_frame(0, k));
            expect_step();
            check_int("strobe_period", last_strobe_cyc - prev_cyc, TICK);
        end

        // COUNT across wrap and BCD carries
        switch_mode(1);
        for (int i = 0; i < 104; i++) expect_step();

        // Back-pressure across three ticks yields one step when busy falls
        printer_busy = 1'b1;
        repeat (35) @(posedge clk);
        #1;
        printer_busy = 1'b0;
        low_cyc = cyc;
        expect_step();
        check_int("busy_release_delay", last_strobe_cyc - low_cyc, 1);
        expect_step();

        // Hold discards ticks and freezes outputs
        hold = 1'b1;
        frozen = exp_frame(1, k);
        repeat (3 * TICK + 3) @(posedge clk);
        #1;
        check_frame("hold_frozen", dut_f, frozen);
        hold = 1'b0;
        expect_step();

        // Mode change while pending: clear now, step in new mode once busy drops
        printer_busy = 1'b1;
        repeat (TICK + 2) @(posedge clk);
        #1;
        switch_mode(2);
        printer_busy = 1'b0;
        low_cyc = cyc;
        expect_step();
        check_int("pending_kept_delay", last_strobe_cyc - low_cyc, 1);
        for (int i = 0; i < 49; i++) expect_step();

        // Mode 3 behaves as TOGGLE
        switch_mode(3);
        expect_step();
        expect_step();

        // Reset during a strobe cycle overrides on that edge
        k++;
        exp_q.push_back(exp_frame(cur_mode, k));
        tag_q.push_back(cur_mode * 1000 + k);
        wait_strobe();
        reset = 1'b0;
        exp_q.delete();
        tag_q.delete();
        @(posedge clk);
        #1;
        check_frame("reset_mid_strobe_frame", dut_f, mk(0, 0, 0, 0, 1'b0, 1'b0));
        check_int("reset_mid_strobe_strobe", int'(strobe), 0);
        reset = 1'b1;
        cur_mode = 3;
        k = 0;
        expect_step();

        // Hand-derived spot values against the logged frames
        for (int i = 0; i < 19; i++) begin
            tg = vecs[i].m * 1000 + vecs[i].k;
            if (dut_log.exists(tg)) begin
                check_frame($sformatf("vec_m%0d_k%0d", vecs[i].m, vecs[i].k), dut_log[tg],
                            mk(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].t, vecs[i].vx, vecs[i].vy));
            end else begin
                checks++;
                errors++;
                $display("FAIL vec_m%0d_k%0d actual=missing required=frame", vecs[i].m, vecs[i].k);
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
